// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit with HI/LO result registers.
// Result is computed at issue and committed after a fixed latency.
module mdu_unit #(
   parameter int WIDTH       = 32,
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       MDOp,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO
);

   localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ?
                         MULT_CYCLES : DIV_CYCLES;
   localparam int CW = $clog2(MAXC + 1);
   localparam logic [CW-1:0] MUL_LD = CW'(MULT_CYCLES - 1);
   localparam logic [CW-1:0] DIV_LD = CW'(DIV_CYCLES - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state, state_nx;
   logic [CW-1:0]    cnt, cnt_nx;
   logic [WIDTH-1:0] phi, plo, phi_nx, plo_nx;
   logic [WIDTH-1:0] hi_nx, lo_nx;
   logic             pcommit, pcommit_nx;

   logic             sgn;
   logic [2*WIDTH-1:0] ea, eb, prod;
   logic [WIDTH-1:0] ma, mb, mbs, quo_u, rem_u, quo, rem;

   // Full-width product and sign-corrected quotient/remainder of A,B.
   always_comb begin
      sgn   = MDOp[0];
      ea    = sgn ? {{WIDTH{A[WIDTH-1]}}, A} : {{WIDTH{1'b0}}, A};
      eb    = sgn ? {{WIDTH{B[WIDTH-1]}}, B} : {{WIDTH{1'b0}}, B};
      prod  = ea * eb;
      ma    = (sgn && A[WIDTH-1]) ? -A : A;
      mb    = (sgn && B[WIDTH-1]) ? -B : B;
      mbs   = (B == '0) ? WIDTH'(1) : mb;
      quo_u = ma / mbs;
      rem_u = ma % mbs;
      quo   = (sgn && (A[WIDTH-1] ^ B[WIDTH-1])) ? -quo_u : quo_u;
      rem   = (sgn && A[WIDTH-1]) ? -rem_u : rem_u;
   end

   // Next-state, pending-result capture and HI/LO update selection.
   always_comb begin
      state_nx   = state;
      cnt_nx     = cnt;
      phi_nx     = phi;
      plo_nx     = plo;
      pcommit_nx = pcommit;
      hi_nx      = HI;
      lo_nx      = LO;
      busy       = (state == RUN);
      unique case (state)
         IDLE: begin
            if (start) begin
               unique case (MDOp)
                  3'd0, 3'd1: begin
                     state_nx   = RUN;
                     cnt_nx     = MUL_LD;
                     phi_nx     = prod[2*WIDTH-1:WIDTH];
                     plo_nx     = prod[WIDTH-1:0];
                     pcommit_nx = 1'b1;
                  end
                  3'd2, 3'd3: begin
                     state_nx   = RUN;
                     cnt_nx     = DIV_LD;
                     phi_nx     = rem;
                     plo_nx     = quo;
                     pcommit_nx = (B != '0);
                  end
                  3'd4:    hi_nx = A;
                  3'd5:    lo_nx = A;
                  default: ;
               endcase
            end
         end
         RUN: begin
            if (cnt != '0) begin
               cnt_nx = cnt - CW'(1);
            end else begin
               state_nx = IDLE;
               if (pcommit) begin
                  hi_nx = phi;
                  lo_nx = plo;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   // Counter, pending result and architectural HI/LO registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt     <= '0;
         phi     <= '0;
         plo     <= '0;
         pcommit <= 1'b0;
         HI      <= '0;
         LO      <= '0;
      end else begin
         cnt     <= cnt_nx;
         phi     <= phi_nx;
         plo     <= plo_nx;
         pcommit <= pcommit_nx;
         HI      <= hi_nx;
         LO      <= lo_nx;
      end
   end

endmodule
